uart_word_serializer: RTL and testbench
=======================================

Name: uart_word_serializer

Overview:
- Upstream feeder for the UART transmitter: accepts a multi-byte result word from the correlator control logic and emits it byte by byte on the transmitter's start/data interface.
- Paces itself on the transmitter's busy output and optionally prefixes each word with a sync byte so the host can frame the stream.
- One word is in flight at a time; a single-word holding register provides the only buffering.

Parameters:
- WORD_BYTES, 4, number of payload bytes per word; payload width W = 8*WORD_BYTES; legal values 1..8.
- SYNC_EN, 1, when 1 each word is preceded by SYNC_BYTE.
- SYNC_BYTE, 8'hA5, value of the framing byte.
- BUSY_TMO, 16, cycles to wait for tx_busy to rise after a start pulse before retrying; legal values >=2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- word_valid  in  1  word_data is valid.
- word_data  in  W  payload word; byte [W-1:W-8] is sent first (MSB first).
- word_ready  out  1  serializer can accept a word this cycle.
- tx_busy  in  1  busy output of the UART transmitter.
- TxD_Start  out  1  one-cycle start pulse to the transmitter.
- TxD_Data  out  8  byte presented to the transmitter.
- sending  out  1  high from word acceptance until the last byte completes.
- err_timeout  out  1  sticky: a start pulse was not acknowledged within BUSY_TMO cycles.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; word_ready=1; TxD_Start=0; TxD_Data=8'h00; sending=0; err_timeout=0; byte index=0; timeout counter=0.
- Handshake: a word is accepted on a cycle with word_valid=1 and word_ready=1. word_ready = (state==IDLE), registered. word_data is captured into the holding register on acceptance; it is not sampled afterwards.
- Sequence length N = WORD_BYTES + SYNC_EN. Byte k=0 is SYNC_BYTE when SYNC_EN=1; payload bytes follow, MSB first.
- FSM:
  - IDLE: on accept, capture word, idx=0, sending=1, go to LOAD.
  - LOAD: TxD_Data=byte[idx]. If tx_busy=0, assert TxD_Start for exactly this one cycle, clear the timeout counter, and go to WAIT_BUSY. If tx_busy=1, stay in LOAD with no pulse.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise increment the timeout counter. When it reaches BUSY_TMO-1, set err_timeout and return to LOAD, which re-issues the same byte.
  - WAIT_DONE: when tx_busy=0, and idx==N-1: go to IDLE and clear sending. Otherwise idx++ and go to LOAD.
- TxD_Data is registered and stays stable from LOAD through the end of WAIT_DONE for that byte.
- TxD_Start is never asserted while tx_busy=1, and never on two consecutive cycles.
- Latency:
  - Accept to first TxD_Start is 1 cycle when tx_busy=0.
  - Between bytes there is 1 cycle from tx_busy falling to the next TxD_Start.
  - word_ready reasserts the cycle after the last byte's tx_busy falls.
- Simultaneous events: word_valid during a transfer is ignored (word_ready=0); the upstream must hold the word.
- Reset mid-transfer aborts immediately. The partial word is discarded and TxD_Start is forced to 0. The transmitter is reset from the same rst, so no half byte remains.
- idx width is clog2(9) = 4 bits. Byte selection is a mux over the holding register; the index never wraps because it is cleared at IDLE.

Decomposition:
- Shared package/header: FSM state encodings (IDLE, LOAD, WAIT_BUSY, WAIT_DONE) and the default SYNC_BYTE constant, reused by the receiver-side deframer.
- No sub-module is needed: a single module holding the FSM, holding register, byte mux and timeout counter.

Test Plan:
- Default parameters; word 0xA1B2C3D4; a transmitter model with busy high for 10 cycles, 1 cycle after each start -> TxD_Data sequence A5, A1, B2, C3, D4. Exactly 5 TxD_Start pulses; sending high throughout; word_ready=1 again afterwards.
- SYNC_EN=0, WORD_BYTES=2; word 0x1234 -> bytes 12, 34 only. The second TxD_Start occurs 1 cycle after busy falls.
- Back-to-back: word_valid held high with 0x11223344 then 0x55667788 -> the second word is accepted only after the first word's last byte completes. The byte stream is unbroken and in the correct order.
- tx_busy held high externally at accept time -> no TxD_Start until busy falls, then the normal sequence.
- Model that ignores the first start pulse (busy stays low 16 cycles) -> err_timeout=1, the same byte (A5) is re-pulsed, and the transfer then completes normally. err_timeout stays at 1 until reset.
- rst asserted during byte 3 of 5 -> all outputs return to reset values asynchronously. After release, a new word 0xDEADBEEF is sent completely from its sync byte.

Source files
------------

// File: rtl/uart_word_serializer_pkg.sv
// Shared definitions for the UART word serializer and the receiver-side
// deframer: FSM state encoding, default framing byte and byte-index width.
package uart_word_serializer_pkg;

  // IDLE      : waiting for a word, word_ready high
  // LOAD      : TxD_Data holds the current byte, waiting for the transmitter to be free
  // WAIT_BUSY : start pulse issued, waiting for the transmitter to acknowledge with busy
  // WAIT_DONE : transmitter is shifting the byte out, waiting for busy to drop
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } ser_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Wide enough for a sync byte plus eight payload bytes (index 0..8).
  localparam int IDX_W = 4;

endpackage

// File: rtl/uart_word_serializer.sv
// uart_word_serializer
//   Takes one multi-byte word from the correlator control logic and feeds it,
//   optionally preceded by a sync byte, byte by byte (MSB first) into a UART
//   transmitter that exposes a start pulse / busy interface.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset (shared with the transmitter)
//   word_valid   upstream word available
//   word_data    payload word, byte [W-1:W-8] sent first
//   word_ready   serializer idle and able to take a word
//   tx_busy      transmitter busy
//   TxD_Start    one-cycle start pulse to the transmitter
//   TxD_Data     byte presented to the transmitter (registered)
//   sending      a word is in flight
//   err_timeout  sticky: some start pulse was not acknowledged in time
//   state_dbg    current FSM state, for observation only
//
// Handshake: a word transfers on a rising edge where word_valid and
// word_ready are both high. word_ready is a register that is high exactly
// while the FSM is in IDLE; it does not depend on word_valid. word_data is
// copied into the holding register on that edge and never sampled again,
// so the upstream may change it as soon as the transfer has happened.
module uart_word_serializer
  import uart_word_serializer_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter int         SYNC_EN    = 1,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int         BUSY_TMO   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    word_valid,
  input  logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_ready,
  input  logic                    tx_busy,
  output logic                    TxD_Start,
  output logic [7:0]              TxD_Data,
  output logic                    sending,
  output logic                    err_timeout,
  output ser_state_t              state_dbg
);

  localparam int W        = 8 * WORD_BYTES;
  localparam int SYNC_OFS = (SYNC_EN != 0) ? 1 : 0;
  localparam int N        = WORD_BYTES + SYNC_OFS;
  localparam int TMO_W    = $clog2(BUSY_TMO);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  ser_state_t       state_q, state_d;
  logic [W-1:0]     hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_d;
  logic [7:0]       data_d;
  logic             start;

  // Byte k of the outgoing sequence: sync byte first (when enabled), then
  // payload bytes from the most significant down.
  function automatic logic [7:0] pick_byte(input logic [W-1:0] word,
                                           input logic [IDX_W-1:0] k);
    logic [7:0] b;
    b = 8'h00;
    if (SYNC_OFS == 1 && k == '0) begin
      b = SYNC_BYTE;
    end else begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (int'(k) == i + SYNC_OFS) b = word[8*(WORD_BYTES-1-i) +: 8];
      end
    end
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    err_d   = err_timeout;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (word_valid && word_ready) begin
          hold_d  = word_data;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Pulse is gated by busy in the same cycle so it can never overlap it.
        if (!tx_busy) begin
          start   = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Pulse was lost; going back to LOAD re-issues the same byte.
          err_d   = 1'b1;
          state_d = LOAD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load the byte register on entry to LOAD; it then holds through WAIT_DONE.
    data_d = TxD_Data;
    if (state_d == LOAD) data_d = pick_byte(hold_d, idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      err_timeout <= 1'b0;
      TxD_Data    <= 8'h00;
      word_ready  <= 1'b1;
      sending     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      err_timeout <= err_d;
      TxD_Data    <= data_d;
      word_ready  <= (state_d == IDLE);
      sending     <= (state_d != IDLE);
    end
  end

  assign TxD_Start = start;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_word_serializer.sv
// Bench for uart_word_serializer: a default instance (4 bytes + sync) and a
// 2-byte instance without sync, each driven by a behavioural UART transmitter
// model, with expected byte streams held in queues.
module tb_uart_word_serializer;
  import uart_word_serializer_pkg::*;

  localparam int         BUSY_LEN  = 10;
  localparam int         BUSY_LEN2 = 4;
  localparam logic [7:0] SYNC      = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main instance ----------------
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        tx_busy;
  logic        TxD_Start;
  logic [7:0]  TxD_Data;
  logic        sending;
  logic        err_timeout;
  ser_state_t  state_dbg;

  uart_word_serializer dut (
    .clk(clk), .rst(rst_n), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .tx_busy(tx_busy), .TxD_Start(TxD_Start),
    .TxD_Data(TxD_Data), .sending(sending), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  // ---------------- 2-byte, no-sync instance ----------------
  logic        word_valid2;
  logic [15:0] word_data2;
  logic        word_ready2;
  logic        tx_busy2;
  logic        TxD_Start2;
  logic [7:0]  TxD_Data2;
  logic        sending2;
  logic        err_timeout2;
  ser_state_t  state_dbg2;

  uart_word_serializer #(.WORD_BYTES(2), .SYNC_EN(0)) dut2 (
    .clk(clk), .rst(rst_n), .word_valid(word_valid2), .word_data(word_data2),
    .word_ready(word_ready2), .tx_busy(tx_busy2), .TxD_Start(TxD_Start2),
    .TxD_Data(TxD_Data2), .sending(sending2), .err_timeout(err_timeout2),
    .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  // main transmitter model / monitor state
  logic busy_m, ext_hold, pend, ignore_next, err_exp;
  int   busy_cnt, bytes_left, acc_cnt, n_starts;
  logic in_flight, done_pending, fall_pending, first_pending, prev_s;
  logic [7:0] last_byte;

  // second transmitter model state
  logic busy2_m, pend2, fall2_pending;
  int   busy2_cnt, bytes_left2, acc2_cnt;

  assign tx_busy  = busy_m | ext_hold;
  assign tx_busy2 = busy2_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- main transmitter model + monitor ----------------
  // Busy rises one cycle after an accepted start pulse and stays high for
  // BUSY_LEN cycles. Optionally the next pulse is ignored entirely.
  always @(negedge clk) begin : mon
    logic s, b, r, v;
    logic [7:0] d;
    s = TxD_Start; b = tx_busy; r = word_ready; v = word_valid; d = TxD_Data;
    if (!rst_n) begin
      busy_m = 0; busy_cnt = 0; pend = 0; in_flight = 0; bytes_left = 0;
      done_pending = 0; fall_pending = 0; first_pending = 0; prev_s = 0;
      ignore_next = 0; err_exp = 0;
    end else begin
      if (done_pending) begin
        check("ready_after_done", r, 1);
        check("sending_after_done", sending, 0);
        check("err_timeout", err_timeout, err_exp);
        done_pending = 0;
      end
      if (fall_pending) begin
        check("start_after_busy_fall", s, 1);
        fall_pending = 0;
      end
      if (first_pending) begin
        check("first_start_latency", s, 1);
        first_pending = 0;
      end
      if (v && r) begin
        check("accept_while_in_flight", in_flight, 0);
        in_flight     = 1;
        bytes_left    = 5;
        first_pending = !b;
        acc_cnt++;
      end
      if (s) begin
        check("start_while_busy", b, 0);
        check("start_back_to_back", prev_s, 0);
        check("sending_during_word", sending, 1);
        check("exp_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tx_byte", d, exp_q.pop_front());
        last_byte = d;
        n_starts++;
      end
      prev_s = s;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          busy_m = 0;
          check("data_held", d, last_byte);
          bytes_left--;
          if (bytes_left == 0) begin
            in_flight    = 0;
            done_pending = 1;
          end else begin
            fall_pending = 1;
          end
        end
      end else if (pend) begin
        pend     = 0;
        busy_m   = 1;
        busy_cnt = BUSY_LEN;
      end
      if (s) begin
        if (ignore_next) begin
          ignore_next = 0;
          err_exp     = 1;
        end else begin
          pend = 1;
        end
      end
    end
  end

  // ---------------- second transmitter model + monitor ----------------
  always @(negedge clk) begin : mon2
    logic s;
    s = TxD_Start2;
    if (!rst_n) begin
      busy2_m = 0; busy2_cnt = 0; pend2 = 0; fall2_pending = 0; bytes_left2 = 0;
    end else begin
      if (fall2_pending) begin
        check("dut2_start_after_busy_fall", s, 1);
        fall2_pending = 0;
      end
      if (word_valid2 && word_ready2) begin
        acc2_cnt++;
        bytes_left2 = 2;
      end
      if (s) begin
        check("dut2_exp_available", exp2_q.size() > 0, 1);
        if (exp2_q.size() > 0) check("dut2_tx_byte", TxD_Data2, exp2_q.pop_front());
      end
      if (busy2_cnt > 0) begin
        busy2_cnt--;
        if (busy2_cnt == 0) begin
          busy2_m = 0;
          bytes_left2--;
          if (bytes_left2 > 0) fall2_pending = 1;
        end
      end else if (pend2) begin
        pend2     = 0;
        busy2_m   = 1;
        busy2_cnt = BUSY_LEN2;
      end
      if (s) pend2 = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int a0;
    a0 = acc_cnt;
    word_valid = 1'b1;
    word_data  = w;
    exp_q.push_back(SYNC);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(w >> (8 * (3 - i))));
    for (int t = 0; t < 300 && acc_cnt == a0; t++) tick();
    check("word_accepted", acc_cnt != a0, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((in_flight || done_pending) && t < 600) begin
      tick();
      t++;
    end
    check("word_completed", in_flight || done_pending, 0);
  endtask

  task automatic send_word2(input logic [15:0] w);
    int a0;
    int t;
    a0 = acc2_cnt;
    word_valid2 = 1'b1;
    word_data2  = w;
    exp2_q.push_back(w[15:8]);
    exp2_q.push_back(w[7:0]);
    for (int k = 0; k < 300 && acc2_cnt == a0; k++) tick();
    check("dut2_word_accepted", acc2_cnt != a0, 1);
    word_valid2 = 1'b0;
    t = 0;
    while (bytes_left2 > 0 && t < 300) begin
      tick();
      t++;
    end
    tick();
    check("dut2_word_completed", bytes_left2, 0);
    check("dut2_ready_after_done", word_ready2, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_ready"}, word_ready, 1);
    check({tag, "_start"}, TxD_Start, 0);
    check({tag, "_data"}, TxD_Data, 8'h00);
    check({tag, "_sending"}, sending, 0);
    check({tag, "_err"}, err_timeout, 0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    rst_n = 1'b0; word_valid = 1'b0; word_data = '0; ext_hold = 1'b0;
    word_valid2 = 1'b0; word_data2 = '0;
    acc_cnt = 0; n_starts = 0; acc2_cnt = 0; last_byte = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    check("dut2_reset_ready", word_ready2, 1);
    check("dut2_reset_err", err_timeout2, 0);
    check("dut2_reset_sending", sending2, 0);
    rst_n = 1'b1;
    tick();

    // Directed word with sync byte.
    send_word(32'hA1B2C3D4);
    word_valid = 1'b0;
    wait_idle();

    // 2-byte instance without sync: directed word then random ones.
    send_word2(16'h1234);
    for (int i = 0; i < 3; i++) send_word2(16'($urandom));

    // Back-to-back: valid held high across two words.
    send_word(32'h11223344);
    send_word(32'h55667788);
    word_valid = 1'b0;
    wait_idle();

    // Transmitter busy at accept time: no pulse until it drops.
    ext_hold = 1'b1;
    send_word($urandom);
    word_valid = 1'b0;
    repeat (20) tick();
    ext_hold = 1'b0;
    wait_idle();

    // Random words, sometimes back-to-back, sometimes with idle gaps.
    for (int i = 0; i < 6; i++) begin
      send_word($urandom);
      if ($urandom_range(0, 1) == 1) begin
        word_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    word_valid = 1'b0;
    wait_idle();

    // First start pulse is lost: sync byte is re-issued after the timeout.
    ignore_next = 1'b1;
    exp_q.push_back(SYNC);
    send_word($urandom);
    word_valid = 1'b0;
    wait_idle();
    // Error flag is sticky across the next word.
    send_word($urandom);
    word_valid = 1'b0;
    wait_idle();

    // Reset during the third byte of a word.
    n0 = n_starts;
    send_word($urandom);
    word_valid = 1'b0;
    for (int t = 0; t < 300 && n_starts < n0 + 3; t++) tick();
    check("third_byte_reached", n_starts >= n0 + 3, 1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    send_word(32'hDEADBEEF);
    word_valid = 1'b0;
    wait_idle();
    check("err_after_reset", err_timeout, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp2_q_drained", exp2_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
